// File: rtl/router_input_terminal_ctrl.sv
// Terminal-port input control for a bidirectional ring: greedy route, bubble check, switch request.
// Latency: combinational from inputs to reqs/in_rdy once out of reset; one register tracks reset.
// Backpressure: the head message stalls (in_rdy=0) until its single request is granted.
module router_input_terminal_ctrl #(
    parameter int p_router_id      = 0,
    parameter int p_num_routers    = 8,
    parameter int p_num_free_nbits = 2,
    localparam int c_dest_nbits    = ($clog2(p_num_routers) > 1) ? $clog2(p_num_routers) : 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [c_dest_nbits-1:0]     dest,
    input  logic                        in_val,
    output logic                        in_rdy,
    input  logic [p_num_free_nbits-1:0] num_free_west,
    input  logic [p_num_free_nbits-1:0] num_free_east,
    output logic [2:0]                  reqs,
    input  logic [2:0]                  grants
);

    // One extra bit so dest + N never overflows before the modulo fold.
    localparam int c_dw = c_dest_nbits + 1;
    localparam logic [c_dw-1:0] c_n  = c_dw'(p_num_routers);
    localparam logic [c_dw-1:0] c_id = c_dw'(p_router_id);
    localparam logic [p_num_free_nbits:0] c_bubble = (p_num_free_nbits + 1)'(2);

    localparam logic [2:0] c_west = 3'b001;
    localparam logic [2:0] c_term = 3'b010;
    localparam logic [2:0] c_east = 3'b100;

    logic            active;
    logic [c_dw-1:0] dest_x;
    logic [c_dw-1:0] dist_e;
    logic [c_dw-1:0] dist_w;
    logic            dest_ok;
    logic [2:0]      route;
    logic            room_ok;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            active <= 1'b0;
        end else begin
            active <= 1'b1;
        end
    end

    assign dest_x  = {1'b0, dest};
    assign dest_ok = (dest_x < c_n);
    assign dist_e  = (dest_x >= c_id) ? (dest_x - c_id) : (dest_x + c_n - c_id);
    assign dist_w  = (c_id >= dest_x) ? (c_id - dest_x) : (c_id + c_n - dest_x);

    always_comb begin
        route   = 3'b000;
        room_ok = 1'b0;
        if (dest_ok) begin
            if (dist_e == '0) begin
                route = c_term;
            end else if (dist_w < dist_e) begin
                route = c_west;
            end else begin
                // Ties on even rings go east.
                route = c_east;
            end
        end
        unique case (route)
            c_west:  room_ok = ({1'b0, num_free_west} >= c_bubble);
            c_east:  room_ok = ({1'b0, num_free_east} >= c_bubble);
            c_term:  room_ok = 1'b1;
            default: room_ok = 1'b0;
        endcase
    end

    assign reqs   = (active && in_val && room_ok) ? route : 3'b000;
    assign in_rdy = active & (|(reqs & grants));

endmodule

// File: tb/tb_router_input_terminal_ctrl.sv
module tb_router_input_terminal_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] dest;
    logic       in_val;
    logic [1:0] num_free_west;
    logic [1:0] num_free_east;
    logic [2:0] grants;
    logic [2:0] reqs8, reqs5;
    logic       rdy8, rdy5;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    router_input_terminal_ctrl #(.p_router_id(2), .p_num_routers(8), .p_num_free_nbits(2)) u8 (
        .clk(clk), .reset_n(reset_n), .dest(dest), .in_val(in_val), .in_rdy(rdy8),
        .num_free_west(num_free_west), .num_free_east(num_free_east),
        .reqs(reqs8), .grants(grants)
    );

    router_input_terminal_ctrl #(.p_router_id(0), .p_num_routers(5), .p_num_free_nbits(2)) u5 (
        .clk(clk), .reset_n(reset_n), .dest(dest), .in_val(in_val), .in_rdy(rdy5),
        .num_free_west(num_free_west), .num_free_east(num_free_east),
        .reqs(reqs5), .grants(grants)
    );

    typedef struct {
        string      name;
        logic       sel5;
        logic [2:0] dest;
        logic       val;
        logic [1:0] fw;
        logic [1:0] fe;
        logic [2:0] gnt;
        logic [2:0] ereqs;
        logic       erdy;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] d, input logic v, input logic [1:0] fw,
                         input logic [1:0] fe, input logic [2:0] g);
        dest = d; in_val = v; num_free_west = fw; num_free_east = fe; grants = g;
    endtask

    function automatic vec_t mk(input string n, input logic s, input logic [2:0] d, input logic v,
                                input logic [1:0] fw, input logic [1:0] fe, input logic [2:0] g,
                                input logic [2:0] er, input logic ed);
        vec_t x;
        x.name = n; x.sel5 = s; x.dest = d; x.val = v; x.fw = fw; x.fe = fe;
        x.gnt = g; x.ereqs = er; x.erdy = ed;
        return x;
    endfunction

    initial begin
        // Ring of 8, id 2
        vecs.push_back(mk("w_d1",        0, 1, 1, 2, 2, 3'b000, 3'b001, 0));
        vecs.push_back(mk("w_d1_gnt",    0, 1, 1, 2, 2, 3'b001, 3'b001, 1));
        vecs.push_back(mk("w_d1_nognt",  0, 1, 1, 2, 2, 3'b000, 3'b001, 0));
        vecs.push_back(mk("e_d3",        0, 3, 1, 2, 2, 3'b000, 3'b100, 0));
        vecs.push_back(mk("e_d4",        0, 4, 1, 2, 2, 3'b000, 3'b100, 0));
        vecs.push_back(mk("e_d5",        0, 5, 1, 2, 2, 3'b000, 3'b100, 0));
        vecs.push_back(mk("w_d7_wrap",   0, 7, 1, 2, 2, 3'b000, 3'b001, 0));
        vecs.push_back(mk("w_d0_wrap",   0, 0, 1, 2, 2, 3'b000, 3'b001, 0));
        vecs.push_back(mk("tie_d6",      0, 6, 1, 2, 2, 3'b000, 3'b100, 0));
        vecs.push_back(mk("term_noval",  0, 2, 0, 2, 2, 3'b010, 3'b000, 0));
        vecs.push_back(mk("term_gnt",    0, 2, 1, 0, 0, 3'b010, 3'b010, 1));
        vecs.push_back(mk("term_nognt",  0, 2, 1, 0, 0, 3'b000, 3'b010, 0));
        vecs.push_back(mk("bub_e1",      0, 3, 1, 2, 1, 3'b100, 3'b000, 0));
        vecs.push_back(mk("bub_w0",      0, 1, 1, 0, 2, 3'b001, 3'b000, 0));
        vecs.push_back(mk("bub_w1_d7",   0, 7, 1, 1, 2, 3'b001, 3'b000, 0));
        vecs.push_back(mk("bub_w2_ok",   0, 1, 1, 2, 0, 3'b000, 3'b001, 0));
        vecs.push_back(mk("bub_e3_ok",   0, 3, 1, 0, 3, 3'b100, 3'b100, 1));
        vecs.push_back(mk("noval_e",     0, 3, 0, 2, 2, 3'b100, 3'b000, 0));
        vecs.push_back(mk("mask_g100",   0, 3, 1, 2, 2, 3'b100, 3'b100, 1));
        vecs.push_back(mk("mask_g001",   0, 3, 1, 2, 2, 3'b001, 3'b100, 0));
        vecs.push_back(mk("mask_g010",   0, 3, 1, 2, 2, 3'b010, 3'b100, 0));
        vecs.push_back(mk("mask_wg100",  0, 1, 1, 2, 2, 3'b100, 3'b001, 0));
        // Ring of 5, id 0
        vecs.push_back(mk("n5_d2",       1, 2, 1, 2, 2, 3'b000, 3'b100, 0));
        vecs.push_back(mk("n5_d1",       1, 1, 1, 2, 2, 3'b000, 3'b100, 0));
        vecs.push_back(mk("n5_d3",       1, 3, 1, 2, 2, 3'b000, 3'b001, 0));
        vecs.push_back(mk("n5_d4",       1, 4, 1, 2, 2, 3'b001, 3'b001, 1));
        vecs.push_back(mk("n5_d0",       1, 0, 1, 2, 2, 3'b010, 3'b010, 1));
        vecs.push_back(mk("n5_d5",       1, 5, 1, 2, 2, 3'b111, 3'b000, 0));
        vecs.push_back(mk("n5_d6",       1, 6, 1, 2, 2, 3'b111, 3'b000, 0));
        vecs.push_back(mk("n5_d7",       1, 7, 1, 3, 3, 3'b111, 3'b000, 0));

        // Reset held: outputs forced low even with a live, grantable request.
        reset_n = 1'b0;
        drive(1, 1, 2, 2, 3'b001);
        @(posedge clk); #1;
        check("rst_reqs8", {1'b0, reqs8}, 4'b0000);
        check("rst_rdy8",  {3'b0, rdy8},  4'b0000);
        drive(0, 1, 2, 2, 3'b010);
        #1;
        check("rst_reqs5", {1'b0, reqs5}, 4'b0000);
        check("rst_rdy5",  {3'b0, rdy5},  4'b0000);

        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        drive(1, 1, 2, 2, 3'b001);
        #1;
        check("post_rst_reqs", {1'b0, reqs8}, 4'b0001);
        check("post_rst_rdy",  {3'b0, rdy8},  4'b0001);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].dest, vecs[i].val, vecs[i].fw, vecs[i].fe, vecs[i].gnt);
            #1;
            if (vecs[i].sel5) begin
                check({vecs[i].name, "_reqs"}, {1'b0, reqs5}, {1'b0, vecs[i].ereqs});
                check({vecs[i].name, "_rdy"},  {3'b0, rdy5},  {3'b0, vecs[i].erdy});
            end else begin
                check({vecs[i].name, "_reqs"}, {1'b0, reqs8}, {1'b0, vecs[i].ereqs});
                check({vecs[i].name, "_rdy"},  {3'b0, rdy8},  {3'b0, vecs[i].erdy});
            end
        end

        // Route follows dest each cycle: no locking across a changing head.
        @(negedge clk); drive(3, 1, 2, 2, 3'b100);
        @(posedge clk); #1;
        check("relock_e", {1'b0, reqs8}, 4'b0100);
        drive(1, 1, 2, 2, 3'b100);
        #1;
        check("relock_w", {1'b0, reqs8}, 4'b0001);
        check("relock_rdy", {3'b0, rdy8}, 4'b0000);

        // Mid-operation reset: outputs stay up until the sampling edge, then drop.
        @(negedge clk); drive(3, 1, 2, 2, 3'b100); reset_n = 1'b0;
        #1;
        check("mid_rst_before", {1'b0, reqs8}, 4'b0100);
        check("mid_rst_before_rdy", {3'b0, rdy8}, 4'b0001);
        @(posedge clk); #1;
        check("mid_rst_after", {1'b0, reqs8}, 4'b0000);
        check("mid_rst_after_rdy", {3'b0, rdy8}, 4'b0000);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_resume", {1'b0, reqs8}, 4'b0100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
